// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared constants for the bit-serial adder: the default operand width, the
// state encodings used by the control FSM, and a helper that sizes the bit
// counter so it can count up to WIDTH.
// ---------------------------------------------------------------------------
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [1:0] STATE_IDLE = 2'd0;
   localparam logic [1:0] STATE_RUN  = 2'd1;
   localparam logic [1:0] STATE_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = STATE_IDLE,
      RUN  = STATE_RUN,
      DONE = STATE_DONE
   } stateT;

   // Counter width needed to represent the values 0..width inclusive.
   function automatic int counterWidth(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// ---------------------------------------------------------------------------
// halfadder / fulladder
// One-bit adder cells used by the serial adder datapath.
//   halfadder : x, y       -> s (x xor y), c (x and y)
//   fulladder : x, y, cin  -> s (sum bit), cout (carry out)
// The full adder is two half adders chained through their sum outputs, with
// the two partial carries merged by an OR gate (they can never both be 1).
// ---------------------------------------------------------------------------
module halfadder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);

   assign s = x ^ y;
   assign c = x & y;

endmodule

module fulladder (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic partialSum;
   logic carryLow;
   logic carryHigh;

   halfadder firstHalf (
      .x (x),
      .y (y),
      .s (partialSum),
      .c (carryLow)
   );

   halfadder secondHalf (
      .x (partialSum),
      .y (cin),
      .s (s),
      .c (carryHigh)
   );

   assign cout = carryLow | carryHigh;

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Adds two WIDTH-bit operands one bit per clock, LSB first, through a single
// full adder. An operation takes WIDTH+2 cycles: the accepting edge, WIDTH
// RUN edges, and one DONE cycle.
//   clk   : clock, all state updates on the rising edge
//   rst   : asynchronous active-high reset
//   start : request an add; accepted only while ready is high
//   a, b  : operands, captured on the accepting edge only
//   ready : high in IDLE (start will be accepted)
//   busy  : high in RUN
//   done  : one-cycle pulse in DONE, new result on sum/cout
//   sum   : (a+b) mod 2^WIDTH, held until the next result
//   cout  : carry out of the top bit, held like sum
// ---------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = counterWidth(WIDTH);

   stateT            state;
   stateT            nextState;
   logic [WIDTH-1:0] shiftA;
   logic [WIDTH-1:0] shiftB;
   logic [WIDTH-1:0] resultReg;
   logic [WIDTH-1:0] resultNext;
   logic             carry;
   logic [CW-1:0]    bitCount;
   logic             sumBit;
   logic             carryNext;
   logic             lastBit;

   fulladder bitAdder (
      .x    (shiftA[0]),
      .y    (shiftB[0]),
      .cin  (carry),
      .s    (sumBit),
      .cout (carryNext)
   );

   // The edge that processes bit WIDTH-1 is the final RUN edge.
   assign lastBit = (bitCount == CW'(WIDTH - 1));

   // New sum bit enters at the MSB while earlier bits move toward the LSB,
   // so after WIDTH shifts bit 0 of the sum has landed in bit 0.
   assign resultNext = {sumBit, {(WIDTH-1){1'b0}}} | (resultReg >> 1);

   // State register: reset forces IDLE immediately, which also aborts any
   // operation in flight so no done pulse is produced for it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic: start only matters in IDLE; RUN ends after the edge
   // that handles the last bit; DONE always lasts one cycle.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = RUN;
         RUN:     if (lastBit) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Status outputs come straight from the state register so there is no
   // combinational path from start to ready/busy/done.
   always_comb begin
      ready = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state)
         IDLE:    ready = 1'b1;
         RUN:     busy  = 1'b1;
         DONE:    done  = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   // Datapath: operands are loaded on the accepting edge, then each RUN edge
   // consumes one LSB from each operand register. The visible sum/cout are
   // only written on the edge that enters DONE, so they keep showing the
   // previous result for the whole of the next operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shiftA    <= '0;
         shiftB    <= '0;
         resultReg <= '0;
         carry     <= 1'b0;
         bitCount  <= '0;
         sum       <= '0;
         cout      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shiftA    <= a;
                  shiftB    <= b;
                  resultReg <= '0;
                  carry     <= 1'b0;
                  bitCount  <= '0;
               end
            end
            RUN: begin
               shiftA    <= shiftA >> 1;
               shiftB    <= shiftB >> 1;
               resultReg <= resultNext;
               carry     <= carryNext;
               bitCount  <= bitCount + CW'(1);
               if (lastBit) begin
                  sum  <= resultNext;
                  cout <= carryNext;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=5. Expected
// {cout,sum} values are pushed to a scoreboard queue when an operation is
// accepted and popped when the selected DUT raises done.
// ---------------------------------------------------------------------------
module tb_serial_adder;

   logic       clk;
   logic       rst;

   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       ready8;
   logic       busy8;
   logic       done8;
   logic [7:0] sum8;
   logic       cout8;

   logic       start5;
   logic [4:0] a5;
   logic [4:0] b5;
   logic       ready5;
   logic       busy5;
   logic       done5;
   logic [4:0] sum5;
   logic       cout5;

   bit         selDut;
   logic       curReady;
   logic       curBusy;
   logic       curDone;
   logic [8:0] curResult;

   logic [8:0] expQ[$];
   logic [8:0] lastRes[2];
   int         acceptCount[2];
   int         pulses8;
   int         pulses5;
   int         errorCount;
   int         checkCount;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .ready (ready8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8)
   );

   serial_adder #(.WIDTH(5)) dut5 (
      .clk   (clk),
      .rst   (rst),
      .start (start5),
      .a     (a5),
      .b     (b5),
      .ready (ready5),
      .busy  (busy5),
      .done  (done5),
      .sum   (sum5),
      .cout  (cout5)
   );

   // Observation mux: the shared tasks look at whichever DUT is selected.
   assign curReady  = selDut ? ready5 : ready8;
   assign curBusy   = selDut ? busy5  : busy8;
   assign curDone   = selDut ? done5  : done8;
   assign curResult = selDut ? {3'b000, cout5, sum5} : {cout8, sum8};

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent count of every done pulse seen on each DUT.
   always @(negedge clk) begin
      if (done8) pulses8 <= pulses8 + 1;
      if (done5) pulses5 <= pulses5 + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s (dut%0d): got %0h expected %0h at %0t", tag, selDut ? 5 : 8, got, exp, $time);
      end
   endtask

   task automatic driveStart(input logic s);
      if (selDut) start5 = s;
      else        start8 = s;
   endtask

   task automatic driveOperands(input logic [7:0] aIn, input logic [7:0] bIn);
      if (selDut) begin
         a5 = aIn[4:0];
         b5 = bIn[4:0];
      end else begin
         a8 = aIn;
         b8 = bIn;
      end
   endtask

   // Wait (bounded) for ready, present operands with start, record the
   // expected result and step to the first RUN cycle.
   task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn, input bit holdStart);
      logic [7:0] am;
      logic [7:0] bm;
      am = selDut ? (aIn & 8'h1F) : aIn;
      bm = selDut ? (bIn & 8'h1F) : bIn;
      for (int i = 0; i < 20 && !curReady; i++) @(negedge clk);
      checkOutput("readyBeforeStart", 32'(curReady), 1);
      driveOperands(am, bm);
      driveStart(1'b1);
      expQ.push_back(9'({1'b0, am}) + 9'({1'b0, bm}));
      acceptCount[selDut]++;
      @(negedge clk);
      if (!holdStart) driveStart(1'b0);
   endtask

   // Count RUN cycles until done, checking the old result is held meanwhile.
   task automatic waitResult(output int busyCycles, output bit gotDone, input bit scramble);
      busyCycles = 0;
      gotDone    = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (curDone) begin
            gotDone = 1'b1;
            break;
         end
         if (curBusy) begin
            busyCycles++;
            checkOutput("holdDuringRun", 32'(curResult), 32'(lastRes[selDut]));
            checkOutput("readyLowInRun", 32'(curReady), 0);
            if (scramble) driveOperands(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         end
         @(negedge clk);
      end
   endtask

   // At the DONE cycle: compare against the scoreboard, then confirm the
   // pulse lasts one cycle and the DUT is back in IDLE.
   task automatic finishOp(input int busyCycles, input bit gotDone);
      logic [8:0] exp;
      if (!gotDone) begin
         checkOutput("doneTimeout", 0, 1);
         return;
      end
      checkOutput("busyCycles", 32'(busyCycles), selDut ? 5 : 8);
      checkOutput("statusInDone", 32'({curReady, curBusy}), 0);
      if (expQ.size() == 0) begin
         checkOutput("unexpectedDone", 1, 0);
      end else begin
         exp = expQ.pop_front();
         checkOutput("result", 32'(curResult), 32'(exp));
         lastRes[selDut] = exp;
      end
      @(negedge clk);
      checkOutput("donePulseWidth", 32'(curDone), 0);
      checkOutput("readyAfterDone", 32'(curReady), 1);
   endtask

   task automatic runOp(input logic [7:0] aIn, input logic [7:0] bIn);
      int bc;
      bit gd;
      applyStimulus(aIn, bIn, 1'b0);
      waitResult(bc, gd, 1'b0);
      finishOp(bc, gd);
   endtask

   // Global time bound so the run always ends.
   initial begin
      #2_000_000;
      checkOutput("watchdog", 0, 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  bc;
      bit  gd;
      bit  doneSeen;

      errorCount  = 0;
      checkCount  = 0;
      pulses8     = 0;
      pulses5     = 0;
      acceptCount[0] = 0;
      acceptCount[1] = 0;
      lastRes[0]  = '0;
      lastRes[1]  = '0;
      selDut      = 1'b0;
      rst         = 1'b1;
      start8      = 1'b0;
      start5      = 1'b0;
      a8 = '0; b8 = '0; a5 = '0; b5 = '0;

      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         selDut = (d == 1);
         #1;
         checkOutput("resetReady", 32'(curReady), 1);
         checkOutput("resetBusyDone", 32'({curBusy, curDone}), 0);
         checkOutput("resetResult", 32'(curResult), 0);
      end
      selDut = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed WIDTH=8 cases including both overflow boundaries.
      runOp(8'h35, 8'h4A);
      runOp(8'hFF, 8'h01);
      runOp(8'hFF, 8'hFF);
      runOp(8'h00, 8'h00);
      runOp(8'h80, 8'h80);

      // start held through RUN with operands changing, then back-to-back.
      applyStimulus(8'h11, 8'h22, 1'b1);
      waitResult(bc, gd, 1'b1);
      finishOp(bc, gd);
      driveOperands(8'h05, 8'h06);
      expQ.push_back(9'h00B);
      acceptCount[0]++;
      @(negedge clk);
      checkOutput("backToBackBusy", 32'(curBusy), 1);
      driveStart(1'b0);
      waitResult(bc, gd, 1'b0);
      finishOp(bc, gd);

      // Reset three cycles into RUN aborts the add.
      applyStimulus(8'h40, 8'h41, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("busyBeforeAbort", 32'(curBusy), 1);
      rst = 1'b1;
      #1;
      checkOutput("abortReady", 32'(curReady), 1);
      checkOutput("abortBusyDone", 32'({curBusy, curDone}), 0);
      checkOutput("abortResult", 32'(curResult), 0);
      void'(expQ.pop_back());
      acceptCount[0]--;
      lastRes[0] = '0;
      @(negedge clk);
      rst = 1'b0;
      doneSeen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         doneSeen = doneSeen | curDone;
         @(negedge clk);
      end
      checkOutput("noDoneAfterAbort", 32'(doneSeen), 0);
      runOp(8'h10, 8'h20);

      // Randomized regression at WIDTH=8.
      for (int i = 0; i < 200; i++) begin
         runOp(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end

      // WIDTH=5: boundaries, then randomized regression.
      selDut = 1'b1;
      runOp(8'h1F, 8'h01);
      runOp(8'h1F, 8'h1F);
      runOp(8'h0A, 8'h05);
      for (int i = 0; i < 200; i++) begin
         runOp(8'($urandom_range(0, 31)), 8'($urandom_range(0, 31)));
      end

      repeat (2) @(negedge clk);
      selDut = 1'b0;
      checkOutput("pulseCount", 32'(pulses8), 32'(acceptCount[0]));
      selDut = 1'b1;
      checkOutput("pulseCount", 32'(pulses5), 32'(acceptCount[1]));
      checkOutput("scoreboardEmpty", 32'(expQ.size()), 0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to add a and b, sampled on a rising clk edge.
REQ-005 The block SHALL have port a, input, WIDTH bits: first operand, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: second operand, captured when start is accepted.
REQ-007 The block SHALL have port ready, output, 1 bit: high only in IDLE, meaning start will be accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high only in RUN.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse marking a new valid result.
REQ-010 The block SHALL have port sum, output, WIDTH bits: result, (a+b) mod 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.

Function
REQ-012 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-013 In IDLE, an edge with start=1 SHALL load a and b into shift registers, clear the internal carry and the bit counter, and enter RUN; call this edge k.
REQ-014 On each RUN edge, the block SHALL add the LSBs of both shift registers and the carry in one full adder, shift the sum bit into the MSB of the result register, store the new carry, and shift both operand registers right by one.
REQ-015 RUN SHALL last exactly WIDTH edges (k+1..k+WIDTH); edge k+WIDTH SHALL enter DONE.
REQ-016 In DONE, sum SHALL show the full result, cout SHALL show the final carry, and done SHALL be 1 for exactly one cycle; edge k+WIDTH+1 SHALL return the block to IDLE.
REQ-017 sum and cout SHALL be updated only on the edge that enters DONE, and SHALL hold the previous result through IDLE and RUN until the next DONE.
REQ-018 start SHALL be ignored in RUN and DONE; there is no queueing, and a, b need to be stable only at the accepting edge.
REQ-019 Back-to-back operation is allowed: start held high SHALL be accepted on the first IDLE edge after DONE, giving a throughput of one result per WIDTH+2 cycles.
REQ-020 Wrap-around: an overflowing sum SHALL be truncated to WIDTH bits and the overflow bit reported on cout; there is no saturation.
REQ-021 ready, busy and done SHALL be decoded directly from the state register, with no combinational path from start.

Reset
REQ-022 While rst=1, independent of clk, the block SHALL force state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, and clear the internal carry, counter and shift registers.
REQ-023 Reset asserted in RUN or DONE SHALL abort the operation with no done pulse; the first edge after rst falls SHALL be able to accept start.

Structure
REQ-024 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL be defined as shared constants in serial_adder_pkg, alongside the WIDTH default.
REQ-025 The bit-level adder SHALL be a sub-module, fulladder (inputs x, y, cin; outputs s, cout), built from two existing halfadder instances plus an OR gate.
REQ-026 The bit counter SHALL be $clog2(WIDTH+1) bits wide.

Verification
REQ-027 The bench SHALL check: WIDTH=8, a=8'h35, b=8'h4A, start pulsed at edge k -> busy on edges k+1..k+8, done=1 after edge k+8, sum=8'h7F, cout=0.
REQ-028 The bench SHALL check overflow: a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; then a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1.
REQ-029 The bench SHALL check that start is ignored while busy: start held high with a and b changed during RUN -> the result reflects the first operands only, and the next operation begins at the IDLE edge after DONE.
REQ-030 The bench SHALL check reset mid-operation: rst asserted 3 cycles into RUN -> immediately ready=1, sum=0, no done pulse; a new add of 8'h10+8'h20 then gives 8'h30.
REQ-031 The bench SHALL run a randomized regression of 200 operations at WIDTH=8 and WIDTH=5, comparing {cout,sum} against a+b on every done pulse, and checking done only in DONE and exactly one pulse per start.
